regfile_wb_arbiter: RTL and testbench

- Writeback-side driver of the single write port of the 32x32 integer register file.
- Accepts results from the ALU and the load/memory unit over valid/ready channels and buffers them in a small FIFO.
- Drains one write per cycle into the register file (rf_w_enable / rf_data_addr / rf_data_in).
- Offers a forwarding lookup so decode can see pending, not-yet-committed values.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/wb_fifo.sv | 69 ++++++
 rtl/regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the integer register-file writeback path.
// Holds register geometry, the pending-write entry and the result source tag.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending register-file writes.
// Exposes the head and every slot so the owner can search pending values.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output wb_entry_t [DEPTH-1:0]       entries,
    output logic [$clog2(DEPTH)-1:0]    rd_ptr,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           cnt_q, cnt_d;
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;

    // Next pointers, occupancy and storage; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage slots carry no reset; only slots inside the count are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head    = mem_q[rd_ptr_q];
    assign entries = mem_q;
    assign rd_ptr  = rd_ptr_q;
    assign count   = cnt_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter driving the single register-file write port.
// Macro REGFILE_WB_FWD_EN enables the pending-value forwarding search.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [AW-1:0]            mem_rd,
    input  logic [DW-1:0]            mem_data,
    output logic                     rf_w_enable,
    output logic [AW-1:0]            rf_data_addr,
    output logic [DW-1:0]            rf_data_in,
    input  logic [AW-1:0]            fwd_addr1,
    input  logic [AW-1:0]            fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data1,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   pending_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]      init_cnt_q, init_cnt_d;
    wb_src_e         rr_last_q, rr_last_d;
    logic            rf_w_enable_q, rf_w_enable_d;
    logic [AW-1:0]   rf_data_addr_q, rf_data_addr_d;
    logic [DW-1:0]   rf_data_in_q, rf_data_in_d;

    logic                  init_done;
    logic                  can_accept;
    logic                  push;
    logic                  pop;
    wb_entry_t             push_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;

    assign init_done  = (init_cnt_q == 2'd2);
    assign can_accept = init_done && (cnt < CW'(DEPTH));
    assign pop        = init_done && (cnt != '0);

    // Grant at most one channel; on a tie the one not granted last wins.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (can_accept) begin
            if (alu_valid && mem_valid) begin
                if (rr_last_q == SRC_ALU) begin
                    mem_ready = 1'b1;
                end else begin
                    alu_ready = 1'b1;
                end
            end else if (alu_valid) begin
                alu_ready = 1'b1;
            end else if (mem_valid) begin
                mem_ready = 1'b1;
            end
        end
    end

    // Select the granted result; x0 destinations complete but are dropped.
    always_comb begin
        push_entry = '{rd: alu_rd, data: alu_data};
        push       = 1'b0;
        rr_last_d  = rr_last_q;
        if (mem_ready) begin
            push_entry = '{rd: mem_rd, data: mem_data};
            push       = (mem_rd != REG_ZERO);
            rr_last_d  = SRC_MEM;
        end else if (alu_ready) begin
            push       = (alu_rd != REG_ZERO);
            rr_last_d  = SRC_ALU;
        end
    end

    // Init window counter and drain of the FIFO head into the rf registers.
    always_comb begin
        init_cnt_d     = init_done ? init_cnt_q : init_cnt_q + 2'd1;
        rf_w_enable_d  = 1'b0;
        rf_data_addr_d = rf_data_addr_q;
        rf_data_in_d   = rf_data_in_q;
        if (pop) begin
            rf_w_enable_d  = 1'b1;
            rf_data_addr_d = head.rd;
            rf_data_in_d   = head.data;
        end
    end

    // Control and write-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt_q     <= 2'd0;
            rr_last_q      <= SRC_ALU;
            rf_w_enable_q  <= 1'b0;
            rf_data_addr_q <= '0;
            rf_data_in_q   <= '0;
        end else begin
            init_cnt_q     <= init_cnt_d;
            rr_last_q      <= rr_last_d;
            rf_w_enable_q  <= rf_w_enable_d;
            rf_data_addr_q <= rf_data_addr_d;
            rf_data_in_q   <= rf_data_in_d;
        end
    end

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .entries   (entries),
        .rd_ptr    (rd_ptr),
        .count     (cnt)
    );

    assign rf_w_enable  = rf_w_enable_q;
    assign rf_data_addr = rf_data_addr_q;
    assign rf_data_in   = rf_data_in_q;
    assign pending_cnt  = cnt;

`ifdef REGFILE_WB_FWD_EN
    logic [PW-1:0] idx;

    // Oldest-to-youngest scan so the youngest matching write wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        if (rf_w_enable_q) begin
            if (rf_data_addr_q == fwd_addr1) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = rf_data_in_q;
            end
            if (rf_data_addr_q == fwd_addr2) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = rf_data_in_q;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < cnt) begin
                if (entries[idx].rd == fwd_addr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = entries[idx].data;
                end
                if (entries[idx].rd == fwd_addr2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = entries[idx].data;
                end
            end
        end
        if (fwd_addr1 == REG_ZERO) begin
            fwd_hit1  = 1'b0;
            fwd_data1 = '0;
        end
        if (fwd_addr2 == REG_ZERO) begin
            fwd_hit2  = 1'b0;
            fwd_data2 = '0;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{fwd_addr1, fwd_addr2, entries, rd_ptr};
    assign fwd_hit1   = (cnt != '0) || rf_w_enable_q;
    assign fwd_hit2   = (cnt != '0) || rf_w_enable_q;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        rf_w_enable;
    logic [4:0]  rf_data_addr;
    logic [31:0] rf_data_in;
    logic [4:0]  fwd_addr1 = '0;
    logic [4:0]  fwd_addr2 = '0;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  pending_cnt;

    regfile_wb_arbiter #(
        .DEPTH(DEPTH),
        .AW(5),
        .DW(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .rf_w_enable (rf_w_enable),
        .rf_data_addr(rf_data_addr),
        .rf_data_in  (rf_data_in),
        .fwd_addr1   (fwd_addr1),
        .fwd_addr2   (fwd_addr2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          m_init = 0;
    int          m_last = 0;
    bit          m_en = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_data = '0;
    bit          e_ar;
    bit          e_mr;
    bit          chk_en = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          glog[$];
    int          wlog[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void mfwd(input int a, output bit h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
`ifdef REGFILE_WB_FWD_EN
        if (a != 0) begin
            if (m_en && m_addr == a) begin
                h = 1'b1;
                d = m_data;
            end
            foreach (mq[i]) begin
                if (mq[i].rd == a) begin
                    h = 1'b1;
                    d = mq[i].data;
                end
            end
        end
`else
        h = (mq.size() != 0) || m_en;
`endif
    endfunction

    task automatic check_now();
        bit          h1, h2;
        logic [31:0] d1, d2;
        e_ar = 1'b0;
        e_mr = 1'b0;
        if (m_init >= 2 && mq.size() < DEPTH) begin
            if (alu_valid && mem_valid) begin
                if (m_last == 0) e_mr = 1'b1;
                else e_ar = 1'b1;
            end else if (alu_valid) begin
                e_ar = 1'b1;
            end else if (mem_valid) begin
                e_mr = 1'b1;
            end
        end
        if (alu_ready && alu_valid) glog.push_back(0);
        if (mem_ready && mem_valid) glog.push_back(1);
        if (rf_w_enable) wlog.push_back(int'(rf_data_addr));
        if (chk_en) begin
            mfwd(int'(fwd_addr1), h1, d1);
            mfwd(int'(fwd_addr2), h2, d2);
            chk("alu_ready", alu_ready, e_ar);
            chk("mem_ready", mem_ready, e_mr);
            chk("pending_cnt", pending_cnt, mq.size());
            chk("rf_w_enable", rf_w_enable, m_en);
            chk("rf_data_addr", rf_data_addr, m_addr);
            chk("rf_data_in", rf_data_in, m_data);
            chk("fwd_hit1", fwd_hit1, h1);
            chk("fwd_hit2", fwd_hit2, h2);
            chk("fwd_data1", fwd_data1, d1);
            chk("fwd_data2", fwd_data2, d2);
        end
    endtask

    task automatic update_model();
        ent_t e;
        if (reset) begin
            mq.delete();
            m_init = 0;
            m_last = 0;
            m_en   = 1'b0;
            m_addr = 0;
            m_data = '0;
        end else begin
            if (m_init >= 2 && mq.size() > 0) begin
                e      = mq.pop_front();
                m_en   = 1'b1;
                m_addr = e.rd;
                m_data = e.data;
            end else begin
                m_en = 1'b0;
            end
            if (e_ar) begin
                m_last = 0;
                if (alu_rd != 0) mq.push_back('{int'(alu_rd), alu_data});
            end else if (e_mr) begin
                m_last = 1;
                if (mem_rd != 0) mq.push_back('{int'(mem_rd), mem_data});
            end
            if (m_init < 2) m_init++;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        check_now();
    endtask

    task automatic to_edge();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic step();
        to_neg();
        to_edge();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    initial begin
        int ai, mi;
        step();
        chk_en = 1'b1;

        // Test 1: init window holds off the handshake.
        reset     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        to_neg(); chk("t1_c1_alu_ready", alu_ready, 0); to_edge();
        to_neg(); chk("t1_c2_alu_ready", alu_ready, 0); to_edge();
        to_neg(); chk("t1_c3_alu_ready", alu_ready, 1); to_edge();
        alu_valid = 1'b0;
        to_neg();
        chk("t1_pending", pending_cnt, 1);
        chk("t1_en_early", rf_w_enable, 0);
        to_edge();
        to_neg();
        chk("t1_en", rf_w_enable, 1);
        chk("t1_addr", rf_data_addr, 5);
        chk("t1_data", rf_data_in, 32'hDEAD_BEEF);
        to_edge();

        // Test 2: round-robin between two always-valid sources.
        do_reset();
        glog.delete();
        wlog.delete();
        ai = 1;
        mi = 11;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        for (int k = 0; k < 20 && glog.size() < 4; k++) begin
            alu_rd   = 5'(ai);
            alu_data = 32'(ai * 100);
            mem_rd   = 5'(mi);
            mem_data = 32'(mi * 100);
            to_neg();
            if (alu_ready) ai++;
            if (mem_ready) mi++;
            to_edge();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (4) step();
        chk("t2_grants", glog.size(), 4);
        chk("t2_writes", wlog.size(), 4);
        if (glog.size() == 4 && wlog.size() == 4) begin
            chk("t2_g0", glog[0], 1);
            chk("t2_g1", glog[1], 0);
            chk("t2_g2", glog[2], 1);
            chk("t2_g3", glog[3], 0);
            chk("t2_w0", wlog[0], 11);
            chk("t2_w1", wlog[1], 1);
            chk("t2_w2", wlog[2], 12);
            chk("t2_w3", wlog[3], 2);
        end

        // Test 3: x0 write is accepted and dropped.
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 32'h1234;
        to_neg(); chk("t3_mem_ready", mem_ready, 1); to_edge();
        mem_valid = 1'b0;
        to_neg();
        chk("t3_pending", pending_cnt, 0);
        chk("t3_en", rf_w_enable, 0);
        to_edge();
        to_neg(); chk("t3_en2", rf_w_enable, 0); to_edge();

        // Test 4: five back-to-back results, none lost, order kept.
        wlog.delete();
        alu_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            alu_rd   = 5'(20 + k);
            alu_data = 32'(32'hA000 + k);
            to_neg();
            chk("t4_alu_ready", alu_ready, 1);
            to_edge();
        end
        alu_valid = 1'b0;
        repeat (3) step();
        chk("t4_writes", wlog.size(), 5);
        if (wlog.size() == 5) begin
            for (int k = 0; k < 5; k++) chk("t4_order", wlog[k], 20 + k);
        end

        // Test 5: youngest pending value wins the lookup.
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'h11;
        step();
        alu_data  = 32'h22;
        step();
        alu_valid = 1'b0;
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd0;
        to_neg();
        chk("t5_hit1", fwd_hit1, 1);
`ifdef REGFILE_WB_FWD_EN
        chk("t5_data1", fwd_data1, 32'h22);
        chk("t5_hit2", fwd_hit2, 0);
`else
        chk("t5_data1", fwd_data1, 0);
        chk("t5_hit2", fwd_hit2, 1);
`endif
        chk("t5_data2", fwd_data2, 0);
        to_edge();
        fwd_addr1 = 5'd0;
        repeat (3) step();

        // Test 6: reset mid-operation discards pending writes.
        alu_valid = 1'b1;
        alu_rd    = 5'd9;
        alu_data  = 32'h99;
        step();
        alu_rd = 5'd10;
        reset  = 1'b1;
        to_neg(); chk("t6_pending_before", pending_cnt, 1); to_edge();
        reset     = 1'b0;
        alu_valid = 1'b0;
        wlog.delete();
        to_neg();
        chk("t6_pending", pending_cnt, 0);
        chk("t6_en", rf_w_enable, 0);
        to_edge();
        repeat (6) step();
        chk("t6_no_stale", wlog.size(), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            alu_valid = ($urandom_range(0, 2) != 0);
            mem_valid = ($urandom_range(0, 2) != 0);
            alu_rd    = 5'($urandom_range(0, 9));
            mem_rd    = 5'($urandom_range(0, 9));
            alu_data  = $urandom();
            mem_data  = $urandom();
            fwd_addr1 = 5'($urandom_range(0, 9));
            fwd_addr2 = 5'($urandom_range(0, 31));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
